// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: opcodes, state encoding and fault codes for the memory-access stage
package mips_mem_pkg;
  localparam logic [5:0] LBU = 6'b100100;
  localparam logic [5:0] LHU = 6'b100101;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] LL  = 6'b110000;
  localparam logic [5:0] SB  = 6'b101000;
  localparam logic [5:0] SH  = 6'b101001;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] SC  = 6'b111000;
  localparam logic [1:0] F_NONE = 2'b00;
  localparam logic [1:0] F_MIS  = 2'b01;
  localparam logic [1:0] F_TMO  = 2'b10;
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  function automatic logic is_load(input logic [5:0] op);
    return op inside {LBU, LHU, LW, LL};
  endfunction
  function automatic logic is_store(input logic [5:0] op);
    return op inside {SB, SH, SW, SC};
  endfunction
endpackage

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: req/ack data-memory bus between the stage and memory
interface mem_access_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  modport master(output mem_req, mem_we, mem_addr, mem_wdata, mem_be, input mem_rdata, mem_ack);
  modport slave(input mem_req, mem_we, mem_addr, mem_wdata, mem_be, output mem_rdata, mem_ack);
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane enables, store replication, load extraction and alignment check
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  a,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic        misaligned
);
  logic byte_op, half_op, word_op;
  always_comb begin
    byte_op = op inside {LBU, SB};
    half_op = op inside {LHU, SH};
    word_op = op inside {LW, LL, SW, SC};
    be = byte_op ? 4'b0001 << a : half_op ? (a[1] ? 4'b1100 : 4'b0011) : word_op ? 4'b1111 : 4'b0000;
    wdata = byte_op ? {4{sdata[7:0]}} : half_op ? {2{sdata[15:0]}} : sdata;
    ldata = byte_op ? {24'b0, rdata[{a, 3'b000} +: 8]} : half_op ? {16'b0, a[1] ? rdata[31:16] : rdata[15:0]} : rdata;
    misaligned = (half_op && a[0]) || (word_op && a != 2'b00);
  end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: load/store memory stage with req/ack handshake, faults and ll/sc link
module mem_access_stage
  import mips_mem_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [5:0]          opcode,
  input  logic [31:0]         addr,
  input  logic [31:0]         store_data,
  output logic                busy,
  output logic                done,
  output logic                reg_write,
  output logic [31:0]         load_data,
  output logic [1:0]          fault,
  mem_access_stage_if.master  mem
);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ACK_TIMEOUT == 0 ? 0 : ACK_TIMEOUT - 1);
  state_t state, state_nx;
  logic [5:0] op_q, al_op;
  logic [31:0] addr_q, sdata_q, al_sd, al_wd, al_ld;
  logic [1:0] al_a, fault_q;
  logic [3:0] al_be;
  logic [CNT_W-1:0] cnt;
  logic [29:0] link_addr;
  logic link_valid, rw_q, misal, sc_miss, supported, timeout, idle;
  mem_lane_align u_align (
    .op(al_op), .a(al_a), .sdata(al_sd), .rdata(mem.mem_rdata),
    .be(al_be), .wdata(al_wd), .ldata(al_ld), .misaligned(misal)
  );
  always_comb begin
    idle = state == IDLE;
    al_op = idle ? opcode : op_q;
    al_a = idle ? addr[1:0] : addr_q[1:0];
    al_sd = idle ? store_data : sdata_q;
    sc_miss = opcode == SC && !(link_valid && link_addr == addr[31:2]);
    supported = is_load(opcode) || is_store(opcode);
    timeout = ACK_TIMEOUT != 0 && cnt >= TMO_LAST;
    state_nx = idle ? (start ? (misal || sc_miss || !supported ? DONE : REQ) : IDLE)
             : state == REQ ? (mem.mem_ack || timeout ? DONE : REQ) : IDLE;
    busy = !idle;
    done = state == DONE;
    reg_write = done && rw_q;
    fault = done ? fault_q : F_NONE;
    mem.mem_req = state == REQ;
    mem.mem_we = mem.mem_req && is_store(op_q);
    mem.mem_addr = mem.mem_req ? {addr_q[31:2], 2'b00} : '0;
    mem.mem_wdata = mem.mem_req ? al_wd : '0;
    mem.mem_be = mem.mem_req ? al_be : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op_q <= '0;
      addr_q <= '0;
      sdata_q <= '0;
      cnt <= '0;
      link_valid <= 1'b0;
      link_addr <= '0;
      rw_q <= 1'b0;
      fault_q <= F_NONE;
      load_data <= '0;
    end else begin
      state <= state_nx;
      if (idle) begin
        cnt <= '0;
        if (start) begin
          op_q <= opcode;
          addr_q <= addr;
          sdata_q <= store_data;
          fault_q <= misal ? F_MIS : F_NONE;
          rw_q <= !misal && sc_miss;
          if (!misal && sc_miss) load_data <= '0;
        end
      end else if (state == REQ) begin
        cnt <= cnt + CNT_W'(cnt != '1);
        if (mem.mem_ack) begin
          fault_q <= F_NONE;
          rw_q <= is_load(op_q) || op_q == SC;
          if (is_load(op_q)) load_data <= al_ld;
          else if (op_q == SC) load_data <= 32'd1;
          if (op_q == LL) begin
            link_valid <= 1'b1;
            link_addr <= addr_q[31:2];
          end else if (op_q == SC || (is_store(op_q) && link_addr == addr_q[31:2])) link_valid <= 1'b0;
        end else if (timeout) begin
          fault_q <= F_TMO;
          rw_q <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: scoreboard bench with a reactive memory responder
module tb_mem_access_stage;
  import mips_mem_pkg::*;
  typedef struct {
    logic        rw;
    logic [1:0]  f;
    logic [31:0] ld;
    logic        chk_ld;
  } exp_t;
  logic clk = 0, reset = 1, start = 0;
  logic [5:0] opcode = '0;
  logic [31:0] addr = '0, store_data = '0, load_data;
  logic busy, done, reg_write;
  logic [1:0] fault;
  int n_chk = 0, n_pass = 0;
  exp_t sb_q[$];
  mem_access_stage_if mif ();
  mem_access_stage #(.ACK_TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .addr(addr),
    .store_data(store_data), .busy(busy), .done(done), .reg_write(reg_write),
    .load_data(load_data), .fault(fault), .mem(mif)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic do_op(input string tag, input logic [5:0] op, input logic [31:0] a, sd, rd,
                       input int ack_at, input logic [31:0] exp_ma, input logic exp_we,
                       input logic [3:0] exp_be, input logic [31:0] exp_wd,
                       input int exp_lat, exp_nreq, input exp_t e);
    int cyc, nreq;
    bit seen;
    exp_t x;
    @(negedge clk);
    start = 1; opcode = op; addr = a; store_data = sd; mif.mem_rdata = rd;
    sb_q.push_back(e);
    cyc = 0; nreq = 0; seen = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      start = 0;
      cyc++;
      if (mif.mem_req) begin
        nreq++;
        if (nreq == 1) begin
          check({tag, "_maddr"}, mif.mem_addr, exp_ma);
          check({tag, "_we"}, 32'(mif.mem_we), 32'(exp_we));
          if (exp_we) begin
            check({tag, "_be"}, 32'(mif.mem_be), 32'(exp_be));
            check({tag, "_wdata"}, mif.mem_wdata, exp_wd);
          end
        end
        mif.mem_ack = nreq == ack_at;
      end else mif.mem_ack = 0;
      if (done) begin
        seen = 1;
        if (sb_q.size() == 0) check({tag, "_sb_empty"}, 32'd0, 32'd1);
        else begin
          x = sb_q.pop_front();
          check({tag, "_rw"}, 32'(reg_write), 32'(x.rw));
          check({tag, "_fault"}, 32'(fault), 32'(x.f));
          if (x.chk_ld) check({tag, "_ld"}, load_data, x.ld);
        end
        check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
      end
    end
    if (!seen) check({tag, "_no_done"}, 32'd0, 32'd1);
    check({tag, "_nreq"}, 32'(nreq), 32'(exp_nreq));
    mif.mem_ack = 0;
  endtask
  initial begin
    bit any_done;
    mif.mem_ack = 0;
    mif.mem_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_req", 32'(mif.mem_req), 0);
    check("rst_rw", 32'(reg_write), 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_ld", load_data, 0);
    check("rst_be", 32'(mif.mem_be), 0);
    check("rst_maddr", mif.mem_addr, 0);
    reset = 0;
    do_op("lbu", LBU, 32'h1003, 0, 32'hA1B2C3D4, 1, 32'h1000, 0, 0, 0, 2, 1, '{1, F_NONE, 32'h000000A1, 1});
    do_op("sh", SH, 32'h2002, 32'h0000BEEF, 0, 1, 32'h2000, 1, 4'b1100, 32'hBEEFBEEF, 2, 1, '{0, F_NONE, 0, 0});
    do_op("lw_mis", LW, 32'h3001, 0, 0, 1, 0, 0, 0, 0, 1, 0, '{0, F_MIS, 0, 0});
    do_op("ll4", LL, 32'h4000, 0, 32'h12345678, 1, 32'h4000, 0, 0, 0, 2, 1, '{1, F_NONE, 32'h12345678, 1});
    do_op("sc4", SC, 32'h4000, 32'd7, 0, 1, 32'h4000, 1, 4'b1111, 32'd7, 2, 1, '{1, F_NONE, 32'd1, 1});
    do_op("sc4_miss", SC, 32'h4000, 32'd7, 0, 1, 0, 0, 0, 0, 1, 0, '{1, F_NONE, 32'd0, 1});
    do_op("ll5", LL, 32'h5000, 0, 32'hCAFEF00D, 1, 32'h5000, 0, 0, 0, 2, 1, '{1, F_NONE, 32'hCAFEF00D, 1});
    do_op("sb5", SB, 32'h5002, 32'h0000005A, 0, 1, 32'h5000, 1, 4'b0100, 32'h5A5A5A5A, 2, 1, '{0, F_NONE, 0, 0});
    do_op("sc5_miss", SC, 32'h5000, 32'd9, 0, 1, 0, 0, 0, 0, 1, 0, '{1, F_NONE, 32'd0, 1});
    do_op("lhu", LHU, 32'h6002, 0, 32'hA1B2C3D4, 2, 32'h6000, 0, 0, 0, 3, 2, '{1, F_NONE, 32'h0000A1B2, 1});
    do_op("lhu_mis", LHU, 32'h6003, 0, 0, 1, 0, 0, 0, 0, 1, 0, '{0, F_MIS, 0, 0});
    do_op("sw", SW, 32'h6004, 32'h01234567, 0, 1, 32'h6004, 1, 4'b1111, 32'h01234567, 2, 1, '{0, F_NONE, 0, 0});
    do_op("lw_tmo", LW, 32'h7000, 0, 0, 0, 32'h7000, 0, 0, 0, 5, 4, '{0, F_TMO, 0, 0});
    do_op("unsup", 6'h00, 32'h0, 0, 0, 1, 0, 0, 0, 0, 1, 0, '{0, F_NONE, 0, 0});
    do_op("ll8", LL, 32'h8000, 0, 32'h11111111, 1, 32'h8000, 0, 0, 0, 2, 1, '{1, F_NONE, 32'h11111111, 1});
    do_op("sc8_tmo", SC, 32'h8000, 32'd3, 0, 0, 32'h8000, 1, 4'b1111, 32'd3, 5, 4, '{0, F_TMO, 0, 0});
    do_op("sc8_hit", SC, 32'h8000, 32'd3, 0, 1, 32'h8000, 1, 4'b1111, 32'd3, 2, 1, '{1, F_NONE, 32'd1, 1});
    @(negedge clk);
    start = 1; opcode = LW; addr = 32'h9000;
    @(negedge clk);
    start = 0;
    check("rstmid_req_before", 32'(mif.mem_req), 1);
    reset = 1;
    @(negedge clk);
    check("rstmid_req", 32'(mif.mem_req), 0);
    check("rstmid_busy", 32'(busy), 0);
    reset = 0;
    any_done = done;
    repeat (6) begin
      @(negedge clk);
      any_done |= done;
    end
    check("rstmid_no_done", 32'(any_done), 0);
    check("sb_drained", 32'(sb_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
